// File: rtl/steer_quad_accel.sv
// Digital/analog steering to 2-bit quadrature converter with step-rate acceleration.
// Held digital steering ramps from DIV_SLOW down to DIV_FAST; analog deflection maps directly to a period.
module steer_quad_accel #(
    parameter int unsigned DIV_SLOW     = 22500,
    parameter int unsigned DIV_FAST     = 7500,
    parameter int unsigned DELTA        = 1500,
    parameter int unsigned ANALOG_SCALE = 118,
    parameter int unsigned DEADZONE     = 16
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              left,
    input  logic              right,
    input  logic              analog_en,
    input  logic signed [7:0] ax,
    output logic        [1:0] steer,
    output logic              step,
    output logic              dir_cw
);

    localparam logic [15:0] P_SLOW = 16'(DIV_SLOW);
    localparam logic [15:0] P_FAST = 16'(DIV_FAST);

    typedef enum logic [1:0] {IDLE, RUN_CW, RUN_CCW} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_CW, REQ_CCW} req_t;

    function automatic logic [6:0] sat_mag(input logic signed [7:0] a);
        if (a == 8'sh80)
            return 7'd127;
        else if (a[7])
            return 7'(-a);
        else
            return 7'(a);
    endfunction

    function automatic logic [15:0] analog_period(input logic [6:0] mag);
        logic [16:0] t;
        t = 17'(DIV_FAST) + 17'(7'd127 - mag) * 17'(ANALOG_SCALE);
        if (t > 17'(DIV_SLOW))
            return P_SLOW;
        else
            return t[15:0];
    endfunction

    function automatic logic [15:0] ramp_down(input logic [15:0] p);
        if (17'(p) >= 17'(DIV_FAST) + 17'(DELTA))
            return p - 16'(DELTA);
        else
            return P_FAST;
    endfunction

    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic cw);
        case (ph)
            2'b00:   return cw ? 2'b01 : 2'b10;
            2'b01:   return cw ? 2'b11 : 2'b00;
            2'b11:   return cw ? 2'b10 : 2'b01;
            default: return cw ? 2'b00 : 2'b11;
        endcase
    endfunction

    logic        r_lft_p0, r_lft_p1, r_rgt_p0, r_rgt_p1;
    state_t      r_state, w_state_n;
    logic [15:0] r_cnt, w_cnt_n;
    logic [15:0] r_period, w_period_n;
    logic [1:0]  w_steer_n;
    logic        w_step_n, w_dir_n;
    req_t        w_req;
    logic        w_analog, w_req_cw;
    logic [6:0]  w_mag;
    logic [15:0] w_target;

    // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_lft_p0 <= 1'b0;
            r_lft_p1 <= 1'b0;
            r_rgt_p0 <= 1'b0;
            r_rgt_p1 <= 1'b0;
        end else begin
            r_lft_p0 <= left;
            r_lft_p1 <= r_lft_p0;
            r_rgt_p0 <= right;
            r_rgt_p1 <= r_rgt_p0;
        end
    end

    assign w_analog = analog_en && !r_lft_p1 && !r_rgt_p1;
    assign w_mag    = sat_mag(ax);
    assign w_target = w_analog ? analog_period(w_mag) : r_period;
    assign w_req_cw = (w_req == REQ_CW);

    always_comb begin
        w_req = REQ_NONE;
        if (r_rgt_p1 && !r_lft_p1)
            w_req = REQ_CW;
        else if (r_lft_p1 && !r_rgt_p1)
            w_req = REQ_CCW;
        else if (w_analog && (w_mag > 7'(DEADZONE)))
            w_req = ax[7] ? REQ_CCW : REQ_CW;
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_period_n = r_period;
        w_steer_n  = steer;
        w_step_n   = 1'b0;
        w_dir_n    = dir_cw;
        if (w_req == REQ_NONE) begin
            if (r_state != IDLE) begin
                w_state_n  = IDLE;
                w_cnt_n    = '0;
                w_period_n = P_SLOW;
            end
        end else if (r_state == IDLE || ((r_state == RUN_CW) != w_req_cw)) begin
            // New or reversed direction steps at once and restarts the ramp
            w_state_n  = w_req_cw ? RUN_CW : RUN_CCW;
            w_cnt_n    = '0;
            w_period_n = P_SLOW;
            w_steer_n  = next_phase(steer, w_req_cw);
            w_step_n   = 1'b1;
            w_dir_n    = w_req_cw;
        end else if ({1'b0, r_cnt} + 17'd1 >= {1'b0, w_target}) begin
            w_cnt_n   = '0;
            w_steer_n = next_phase(steer, w_req_cw);
            w_step_n  = 1'b1;
            if (!w_analog)
                w_period_n = ramp_down(r_period);
        end else begin
            w_cnt_n = r_cnt + 16'd1;
        end
    end

    // Stage p2: registered state and quadrature outputs
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_period <= P_SLOW;
            steer    <= 2'b00;
            step     <= 1'b0;
            dir_cw   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_period <= w_period_n;
            steer    <= w_steer_n;
            step     <= w_step_n;
            dir_cw   <= w_dir_n;
        end
    end

endmodule

// File: tb/tb_steer_quad_accel.sv
// Scoreboard bench for steer_quad_accel using scaled-down periods so whole ramps fit in a short run.
module tb_steer_quad_accel;

    localparam int DS = 225;
    localparam int DF = 75;
    localparam int DL = 15;
    localparam int AS = 2;
    localparam int DZ = 16;
    localparam logic [1:0] SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic              CLK = 1'b0;
    logic              Reset_n = 1'b0;
    logic              left = 1'b0;
    logic              right = 1'b0;
    logic              analog_en = 1'b0;
    logic signed [7:0] ax = 8'sd0;
    logic        [1:0] steer;
    logic              step;
    logic              dir_cw;

    steer_quad_accel #(
        .DIV_SLOW(DS), .DIV_FAST(DF), .DELTA(DL), .ANALOG_SCALE(AS), .DEADZONE(DZ)
    ) dut (
        .CLK(CLK), .Reset_n(Reset_n), .left(left), .right(right),
        .analog_en(analog_en), .ax(ax), .steer(steer), .step(step), .dir_cw(dir_cw)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         dly;
        logic [1:0] st;
        logic       cw;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   ph     = 0;

    task automatic push_exp(input int dly, input bit cw);
        ph = cw ? (ph + 1) % 4 : (ph + 3) % 4;
        sb.push_back('{dly, SEQ[ph], cw});
    endtask

    task automatic get_step(input int budget, output bit found, output int dly);
        found = 1'b0;
        dly   = 0;
        while (!found && dly < budget) begin
            @(posedge CLK); #1;
            dly++;
            if (step) found = 1'b1;
        end
    endtask

    task automatic count_steps(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(posedge CLK); #1;
            if (step) c++;
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; left = 1'b0; right = 1'b0; analog_en = 1'b0; ax = 8'sd0;
        sb.delete();
        ph = 0;
        repeat (2) @(posedge CLK);
        #1 Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int c;
        @(posedge CLK); #1;
        n_run++;
        if (steer !== 2'b00) begin
            n_fail++; $display("FAIL reset_steer: got %b want 00", steer);
        end
        n_run++;
        if (step !== 1'b0) begin
            n_fail++; $display("FAIL reset_step: got %b want 0", step);
        end
        n_run++;
        if (dir_cw !== 1'b0) begin
            n_fail++; $display("FAIL reset_dir: got %b want 0", dir_cw);
        end
        @(posedge CLK); #1 Reset_n = 1'b1;
        count_steps(2000, c);
        n_run++;
        if (c !== 0 || steer !== 2'b00) begin
            n_fail++; $display("FAIL idle_no_input: steps=%0d steer=%b want 0 steps steer 00", c, steer);
        end
    endtask

    task automatic test_ramp();
        exp_t e; bit f; int d; int p; int c;
        do_reset();
        right = 1'b1;
        push_exp(3, 1'b1);
        p = DS;
        for (int i = 0; i < 13; i++) begin
            push_exp(p, 1'b1);
            p = (p - DL < DF) ? DF : p - DL;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_step(e.dly + 10, f, d);
            n_run++;
            if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
                n_fail++;
                $display("FAIL ramp_step: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                         f, d, steer, dir_cw, e.dly, e.st, e.cw);
            end
        end
        right = 1'b0;
        count_steps(300, c);
        n_run++;
        if (c !== 0 || steer !== SEQ[ph]) begin
            n_fail++; $display("FAIL ramp_release: steps=%0d steer=%b want 0 steps steer %b", c, steer, SEQ[ph]);
        end
    endtask

    task automatic test_reverse();
        exp_t e; bit f; int d;
        do_reset();
        right = 1'b1;
        push_exp(3, 1'b1);
        push_exp(225, 1'b1);
        push_exp(210, 1'b1);
        push_exp(195, 1'b1);
        push_exp(180, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_step(e.dly + 10, f, d);
            n_run++;
            if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
                n_fail++;
                $display("FAIL reverse_cw: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                         f, d, steer, dir_cw, e.dly, e.st, e.cw);
            end
        end
        right = 1'b0;
        left  = 1'b1;
        push_exp(3, 1'b0);
        push_exp(DS, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_step(e.dly + 10, f, d);
            n_run++;
            if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
                n_fail++;
                $display("FAIL reverse_ccw: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                         f, d, steer, dir_cw, e.dly, e.st, e.cw);
            end
        end
        left = 1'b0;
    endtask

    task automatic test_both();
        exp_t e; bit f; int d; int c;
        do_reset();
        right = 1'b1;
        push_exp(3, 1'b1);
        e = sb.pop_front();
        get_step(e.dly + 10, f, d);
        n_run++;
        if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
            n_fail++;
            $display("FAIL both_first: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                     f, d, steer, dir_cw, e.dly, e.st, e.cw);
        end
        left = 1'b1;
        count_steps(400, c);
        n_run++;
        if (c !== 0 || steer !== 2'b01) begin
            n_fail++; $display("FAIL both_hold: steps=%0d steer=%b want 0 steps steer 01", c, steer);
        end
        right = 1'b0;
        push_exp(3, 1'b0);
        e = sb.pop_front();
        get_step(e.dly + 10, f, d);
        n_run++;
        if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
            n_fail++;
            $display("FAIL both_release: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                     f, d, steer, dir_cw, e.dly, e.st, e.cw);
        end
        left = 1'b0;
    endtask

    task automatic test_analog();
        exp_t e; bit f; int d; int c;
        do_reset();
        analog_en = 1'b1;
        ax = 8'sd127;
        push_exp(1, 1'b1);
        push_exp(DF, 1'b1);
        push_exp(DF, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_step(e.dly + 10, f, d);
            n_run++;
            if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
                n_fail++;
                $display("FAIL analog_pos: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                         f, d, steer, dir_cw, e.dly, e.st, e.cw);
            end
        end
        ax = -8'sd128;
        push_exp(1, 1'b0);
        push_exp(DF, 1'b0);
        push_exp(DF, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_step(e.dly + 10, f, d);
            n_run++;
            if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
                n_fail++;
                $display("FAIL analog_neg: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                         f, d, steer, dir_cw, e.dly, e.st, e.cw);
            end
        end
        ax = 8'sd16;
        count_steps(300, c);
        n_run++;
        if (c !== 0 || steer !== SEQ[ph]) begin
            n_fail++; $display("FAIL analog_deadzone: steps=%0d steer=%b want 0 steps steer %b", c, steer, SEQ[ph]);
        end
        // +17 gives 75+110*2=295, clamped to 225; +60 gives 75+67*2=209
        ax = 8'sd17;
        push_exp(1, 1'b1);
        push_exp(DS, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_step(e.dly + 10, f, d);
            n_run++;
            if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
                n_fail++;
                $display("FAIL analog_clamp: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                         f, d, steer, dir_cw, e.dly, e.st, e.cw);
            end
        end
        ax = 8'sd60;
        push_exp(209, 1'b1);
        e = sb.pop_front();
        get_step(e.dly + 10, f, d);
        n_run++;
        if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
            n_fail++;
            $display("FAIL analog_mid: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                     f, d, steer, dir_cw, e.dly, e.st, e.cw);
        end
        ax = 8'sd0;
        analog_en = 1'b0;
    endtask

    task automatic test_mode_switch();
        exp_t e; bit f; int d; int c;
        do_reset();
        right = 1'b1;
        push_exp(3, 1'b1);
        e = sb.pop_front();
        get_step(e.dly + 10, f, d);
        n_run++;
        if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
            n_fail++;
            $display("FAIL mode_first: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                     f, d, steer, dir_cw, e.dly, e.st, e.cw);
        end
        analog_en = 1'b1;
        ax = 8'sd127;
        count_steps(100, c);
        n_run++;
        if (c !== 0) begin
            n_fail++; $display("FAIL mode_digital_wins: steps=%0d want 0", c);
        end
        // cnt is already past the fast analog target, so the step lands as soon as the release syncs
        right = 1'b0;
        push_exp(3, 1'b1);
        push_exp(DF, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_step(e.dly + 10, f, d);
            n_run++;
            if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
                n_fail++;
                $display("FAIL mode_switch: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                         f, d, steer, dir_cw, e.dly, e.st, e.cw);
            end
        end
        analog_en = 1'b0;
        ax = 8'sd0;
    endtask

    task automatic test_reset_mid();
        exp_t e; bit f; int d; int c;
        do_reset();
        right = 1'b1;
        push_exp(3, 1'b1);
        push_exp(DS, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_step(e.dly + 10, f, d);
            n_run++;
            if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
                n_fail++;
                $display("FAIL midrst_pre: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                         f, d, steer, dir_cw, e.dly, e.st, e.cw);
            end
        end
        count_steps(57, c);
        Reset_n = 1'b0;
        #2;
        n_run++;
        if (steer !== 2'b00 || step !== 1'b0 || dir_cw !== 1'b0 || c !== 0) begin
            n_fail++;
            $display("FAIL midrst_clear: steer=%b step=%b dir=%b steps=%0d want 00 0 0 0", steer, step, dir_cw, c);
        end
        @(posedge CLK); #1;
        Reset_n = 1'b1;
        ph = 0;
        push_exp(3, 1'b1);
        push_exp(DS, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_step(e.dly + 10, f, d);
            n_run++;
            if (!f || d !== e.dly || steer !== e.st || dir_cw !== e.cw) begin
                n_fail++;
                $display("FAIL midrst_post: found=%0b dly=%0d steer=%b dir=%b want dly=%0d steer=%b dir=%b",
                         f, d, steer, dir_cw, e.dly, e.st, e.cw);
            end
        end
        right = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reverse();
        test_both();
        test_analog();
        test_mode_switch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
